// File: rtl/pkt_capture_sched.sv
// Packet capture scheduler: walks ADC lane/half slots and frames them into
// fixed-length packets, in single-shot or continuous mode with an idle gap.
//
// Ports:
//   pktctrl_clk, pktctrl_rst      clock, synchronous active-high reset
//   rf_capture_mode               0 = single packet, 1 = continuous
//   rf_capture_start              level; rising edge requests a capture
//   rf_capture_again              pulse; re-arms from DONE
//   rf_96path_en                  1 = 24 lanes, 0 = lanes 0..11
//   rf_pkt_data_length            00=64, 01=128, 10=256, 11=512 words
//   rf_pkt_idle_length            idle cycles between packets
//   DATA_RD_EN                    downstream consumes one word per cycle
//   lane_sel, half_sel            current slot (registered)
//   sched_valid/sop/eop           word framing (combinational from state)
//   sched_busy, sched_done        SEND/GAP, DONE
//   pkt_cnt                       completed packets
//
// Build option: define PKT_SCHED_PKT_CNT_EN to implement the packet counter;
// otherwise pkt_cnt is tied to zero.
module pkt_capture_sched #(
  parameter int unsigned PKT_CNT_W = 16
) (
  input  logic                 pktctrl_clk,
  input  logic                 pktctrl_rst,
  input  logic                 rf_capture_mode,
  input  logic                 rf_capture_start,
  input  logic                 rf_capture_again,
  input  logic                 rf_96path_en,
  input  logic [1:0]           rf_pkt_data_length,
  input  logic [15:0]          rf_pkt_idle_length,
  input  logic                 DATA_RD_EN,
  output logic [4:0]           lane_sel,
  output logic                 half_sel,
  output logic                 sched_valid,
  output logic                 sched_sop,
  output logic                 sched_eop,
  output logic                 sched_busy,
  output logic                 sched_done,
  output logic [PKT_CNT_W-1:0] pkt_cnt
);

  localparam int unsigned LANE_W = 5;
  localparam int unsigned WCNT_W = 9;
  localparam int unsigned IDLE_W = 16;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DONE} state_t;

  state_t              state, state_nxt;
  logic                load;
  logic                start_q;
  logic                start_block_q;
  logic                start_rise;
  logic                path96_q;
  logic [1:0]          len_q;
  logic [IDLE_W-1:0]   idle_q;
  logic [WCNT_W-1:0]   word_cnt;
  logic [WCNT_W-1:0]   word_last;
  logic [IDLE_W-1:0]   gap_cnt;
  logic [LANE_W-1:0]   lane_max;

  // A start level held through reset is blocked until it has been seen low.
  assign start_rise = rf_capture_start & ~start_q & ~start_block_q;

  assign sched_valid = (state == ST_SEND) && DATA_RD_EN;
  assign sched_sop   = sched_valid && (word_cnt == '0);
  assign sched_eop   = sched_valid && (word_cnt == word_last);
  assign sched_busy  = (state == ST_SEND) || (state == ST_GAP);
  assign sched_done  = (state == ST_DONE);

  assign lane_max = path96_q ? LANE_W'(23) : LANE_W'(11);

  // Last word index of a packet from the latched length code.
  always_comb begin
    word_last = WCNT_W'(63);
    case (len_q)
      2'b00:   word_last = WCNT_W'(63);
      2'b01:   word_last = WCNT_W'(127);
      2'b10:   word_last = WCNT_W'(255);
      default: word_last = WCNT_W'(511);
    endcase
  end

  // State register.
  always_ff @(posedge pktctrl_clk) begin
    if (pktctrl_rst) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Next-state logic; load marks a fresh capture (latch config, reset slot).
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_rise) begin
          state_nxt = ST_SEND;
          load      = 1'b1;
        end
      end
      ST_SEND: begin
        if (sched_eop) begin
          if (!rf_capture_mode || !rf_capture_start) state_nxt = ST_DONE;
          else if (idle_q != '0)                     state_nxt = ST_GAP;
          else                                       state_nxt = ST_SEND;
        end
      end
      ST_GAP: begin
        if (gap_cnt == idle_q - IDLE_W'(1))
          state_nxt = rf_capture_start ? ST_SEND : ST_DONE;
      end
      ST_DONE: begin
        if (rf_capture_again) begin
          state_nxt = ST_SEND;
          load      = 1'b1;
        end else if (!rf_capture_start) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Start edge detect, config latch, slot walk, word and gap counters.
  always_ff @(posedge pktctrl_clk) begin
    if (pktctrl_rst) begin
      start_q       <= 1'b0;
      start_block_q <= rf_capture_start;
      path96_q      <= 1'b0;
      len_q         <= 2'b00;
      idle_q        <= '0;
      lane_sel      <= '0;
      half_sel      <= 1'b0;
      word_cnt      <= '0;
      gap_cnt       <= '0;
    end else begin
      start_q <= rf_capture_start;
      if (!rf_capture_start) start_block_q <= 1'b0;

      if (load) begin
        path96_q <= rf_96path_en;
        len_q    <= rf_pkt_data_length;
        idle_q   <= rf_pkt_idle_length;
        lane_sel <= '0;
        half_sel <= 1'b0;
        word_cnt <= '0;
      end else if (sched_valid) begin
        half_sel <= ~half_sel;
        if (half_sel)
          lane_sel <= (lane_sel == lane_max) ? '0 : lane_sel + LANE_W'(1);
        word_cnt <= sched_eop ? '0 : word_cnt + WCNT_W'(1);
      end

      gap_cnt <= (state == ST_GAP) ? gap_cnt + IDLE_W'(1) : '0;
    end
  end

`ifdef PKT_SCHED_PKT_CNT_EN
  logic [PKT_CNT_W-1:0] pkt_cnt_q;

  // Completed-packet counter, wraps naturally.
  always_ff @(posedge pktctrl_clk) begin
    if (pktctrl_rst)    pkt_cnt_q <= '0;
    else if (sched_eop) pkt_cnt_q <= pkt_cnt_q + PKT_CNT_W'(1);
  end

  assign pkt_cnt = pkt_cnt_q;
`else
  assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_capture_sched.sv
// Randomized self-checking bench for pkt_capture_sched. Expected slots and
// framing are derived from the global word index of a capture.
module tb_pkt_capture_sched;

  localparam int unsigned PKT_CNT_W = 16;

  logic                 pktctrl_clk = 1'b0;
  logic                 pktctrl_rst;
  logic                 rf_capture_mode;
  logic                 rf_capture_start;
  logic                 rf_capture_again;
  logic                 rf_96path_en;
  logic [1:0]           rf_pkt_data_length;
  logic [15:0]          rf_pkt_idle_length;
  logic                 DATA_RD_EN;
  logic [4:0]           lane_sel;
  logic                 half_sel;
  logic                 sched_valid;
  logic                 sched_sop;
  logic                 sched_eop;
  logic                 sched_busy;
  logic                 sched_done;
  logic [PKT_CNT_W-1:0] pkt_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_model = 0;

  always #5 pktctrl_clk = ~pktctrl_clk;

  pkt_capture_sched #(.PKT_CNT_W(PKT_CNT_W)) dut (
    .pktctrl_clk        (pktctrl_clk),
    .pktctrl_rst        (pktctrl_rst),
    .rf_capture_mode    (rf_capture_mode),
    .rf_capture_start   (rf_capture_start),
    .rf_capture_again   (rf_capture_again),
    .rf_96path_en       (rf_96path_en),
    .rf_pkt_data_length (rf_pkt_data_length),
    .rf_pkt_idle_length (rf_pkt_idle_length),
    .DATA_RD_EN         (DATA_RD_EN),
    .lane_sel           (lane_sel),
    .half_sel           (half_sel),
    .sched_valid        (sched_valid),
    .sched_sop          (sched_sop),
    .sched_eop          (sched_eop),
    .sched_busy         (sched_busy),
    .sched_done         (sched_done),
    .pkt_cnt            (pkt_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_cnt();
`ifdef PKT_SCHED_PKT_CNT_EN
    return cnt_model % (1 << PKT_CNT_W);
`else
    return 0;
`endif
  endfunction

  task automatic step();
    @(posedge pktctrl_clk);
    #1;
  endtask

  // trig 0: start rising edge from IDLE; trig 1: again pulse from DONE.
  // rd_pct < 0 selects the 1,0,0,1 read-enable pattern.
  task automatic run_capture(input int trig, input bit mode, input bit p96, input int len,
                             input int idle, input int rd_pct, input int drop_pkt);
    int L, nl, g, k, pkts, exp_pkts, last_eop, first_sop, p;
    bit done_seen, rd;
    L = 64 << len;
    nl = p96 ? 24 : 12;
    g = 0; k = 0; pkts = 0; last_eop = -1; first_sop = -1; done_seen = 0;
    exp_pkts = mode ? drop_pkt + 1 : 1;
    rf_capture_mode    = mode;
    rf_96path_en       = p96;
    rf_pkt_data_length = 2'(len);
    rf_pkt_idle_length = 16'(idle);
    DATA_RD_EN         = 1'b1;
    if (trig == 0) rf_capture_start = 1'b1;
    else begin
      rf_capture_again = 1'b1;
      rf_capture_start = 1'b0;
    end
    @(negedge pktctrl_clk);
    check("trig_valid", 32'(sched_valid), 0);
    step();
    rf_capture_again = 1'b0;
    for (int cyc = 1; cyc < 6000 && !done_seen; cyc++) begin
      // Config churn and stray again pulses during a capture must be ignored.
      rf_96path_en       = 1'($urandom);
      rf_pkt_data_length = 2'($urandom);
      rf_pkt_idle_length = 16'($urandom_range(0, 9));
      rf_capture_again   = (pkts < exp_pkts) && ($urandom_range(0, 7) == 0);
      if (rd_pct < 0) begin
        p = (cyc - 1) % 4;
        rd = (p == 0) || (p == 3);
      end else begin
        rd = ($urandom_range(0, 99) < rd_pct);
      end
      DATA_RD_EN = rd;
      if (mode && pkts == drop_pkt && k >= L / 2) rf_capture_start = 1'b0;
      @(negedge pktctrl_clk);
      if (sched_done) begin
        done_seen = 1;
        check("done_valid", 32'(sched_valid), 0);
        check("done_busy", 32'(sched_busy), 0);
        cnt_model += pkts;
        check("pkt_cnt", 32'(pkt_cnt), exp_cnt());
      end else begin
        check("busy", 32'(sched_busy), 1);
        check("lane", 32'(lane_sel), (g / 2) % nl);
        check("half", 32'(half_sel), g % 2);
        if (!rd) check("valid_gated", 32'(sched_valid), 0);
        if (sched_valid) begin
          check("sop", 32'(sched_sop), (k == 0) ? 1 : 0);
          check("eop", 32'(sched_eop), (k == L - 1) ? 1 : 0);
          if (k == 0) begin
            if (first_sop < 0) first_sop = cyc;
            else if (rd_pct == 100) check("gap_len", cyc - last_eop - 1, idle);
          end
          if (k == L - 1) begin
            pkts++;
            last_eop = cyc;
          end
          g++;
          k = (k + 1) % L;
        end
      end
      step();
    end
    rf_capture_again = 1'b0;
    check("done_reached", 32'(done_seen), 1);
    check("pkt_total", pkts, exp_pkts);
    check("word_total", g, exp_pkts * L);
    if (rd_pct == 100) check("first_latency", first_sop, 1);
  endtask

  task automatic to_idle();
    rf_capture_start = 1'b0;
    rf_capture_again = 1'b0;
    step();
    @(negedge pktctrl_clk);
    check("idle_done", 32'(sched_done), 0);
    check("idle_busy", 32'(sched_busy), 0);
    step();
  endtask

  initial begin
    pktctrl_rst        = 1'b1;
    rf_capture_mode    = 1'b0;
    rf_capture_start   = 1'b0;
    rf_capture_again   = 1'b0;
    rf_96path_en       = 1'b1;
    rf_pkt_data_length = 2'b00;
    rf_pkt_idle_length = 16'd0;
    DATA_RD_EN         = 1'b0;
    repeat (3) step();
    @(negedge pktctrl_clk);
    check("rst_busy", 32'(sched_busy), 0);
    check("rst_done", 32'(sched_done), 0);
    check("rst_lane", 32'(lane_sel), 0);
    check("rst_cnt", 32'(pkt_cnt), 0);
    step();
    pktctrl_rst = 1'b0;
    step();

    // Again pulse in IDLE does nothing.
    rf_capture_again = 1'b1;
    step();
    rf_capture_again = 1'b0;
    @(negedge pktctrl_clk);
    check("again_idle", 32'(sched_busy), 0);
    step();

    // Single packet, 24 lanes; DONE holds while start stays high.
    run_capture(0, 1'b0, 1'b1, 0, 3, 100, 0);
    @(negedge pktctrl_clk);
    check("done_hold", 32'(sched_done), 1);
    step();
    to_idle();

    // 12-lane wrap, 128 words.
    run_capture(0, 1'b0, 1'b0, 1, 0, 100, 0);
    to_idle();

    // Read-enable 1,0,0,1 pattern.
    run_capture(0, 1'b0, 1'b1, 0, 0, -1, 0);
    to_idle();

    // Continuous with idle 5, start dropped in the third packet.
    run_capture(0, 1'b1, 1'b1, 0, 5, 100, 2);
    to_idle();

    // Back-to-back packets.
    run_capture(0, 1'b1, 1'b0, 0, 0, 100, 1);
    to_idle();

    // Random captures.
    for (int i = 0; i < 4; i++) begin
      run_capture(0, 1'($urandom), 1'($urandom), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 6)), ($urandom_range(0, 1) == 0) ? 100 : 70,
                  int'($urandom_range(0, 2)));
      to_idle();
    end

    // Re-arm from DONE; again wins over start low in the same cycle.
    run_capture(0, 1'b0, 1'b1, 0, 0, 100, 0);
    run_capture(1, 1'b0, 1'b0, 0, 0, 100, 0);
    to_idle();

    // Reset mid-SEND, then a start level held across reset must not capture.
    rf_capture_mode    = 1'b1;
    rf_96path_en       = 1'b1;
    rf_pkt_data_length = 2'b00;
    rf_pkt_idle_length = 16'd3;
    DATA_RD_EN         = 1'b1;
    rf_capture_start   = 1'b1;
    repeat (20) step();
    pktctrl_rst = 1'b1;
    step();
    @(negedge pktctrl_clk);
    check("mrst_valid", 32'(sched_valid), 0);
    check("mrst_sop", 32'(sched_sop), 0);
    check("mrst_eop", 32'(sched_eop), 0);
    check("mrst_busy", 32'(sched_busy), 0);
    check("mrst_done", 32'(sched_done), 0);
    check("mrst_lane", 32'(lane_sel), 0);
    check("mrst_half", 32'(half_sel), 0);
    check("mrst_cnt", 32'(pkt_cnt), 0);
    cnt_model = 0;
    step();
    pktctrl_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge pktctrl_clk);
      check("held_start", 32'(sched_busy), 0);
    end
    step();
    rf_capture_start = 1'b0;
    step();
    step();
    run_capture(0, 1'b0, 1'b1, 0, 0, 100, 0);
    to_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_capture_sched.md
PKT_CAPTURE_SCHED -- requirements
Module: pkt_capture_sched

Interface
REQ-001 The block SHALL have parameter PKT_CNT_W, default 16, giving the width of the packet counter.
REQ-002 The block SHALL have a single clock, pktctrl_clk, and all state SHALL be registered on its rising edge.
REQ-003 Port pktctrl_clk  input  1  block clock.
REQ-004 Port pktctrl_rst  input  1  synchronous, active-high reset.
REQ-005 Port rf_capture_mode  input  1  capture mode: 0 = single packet, 1 = continuous.
REQ-006 Port rf_capture_start  input  1  level input; a rising edge requests a capture.
REQ-007 Port rf_capture_again  input  1  one-cycle pulse that re-arms the block from DONE.
REQ-008 Port rf_96path_en  input  1  1 = 24 lanes active, 0 = lanes 0..11 only.
REQ-009 Port rf_pkt_data_length  input  2  packet length: 00=64, 01=128, 10=256, 11=512 words.
REQ-010 Port rf_pkt_idle_length  input  16  idle gap between packets, in cycles.
REQ-011 Port DATA_RD_EN  input  1  downstream read enable; one word is consumed per cycle while high.
REQ-012 Port lane_sel  output  5  ADC lane index, 0..23.
REQ-013 Port half_sel  output  1  18-bit half of the 36-bit lane: 0 = [17:0], 1 = [35:18].
REQ-014 Port sched_valid, sched_sop, sched_eop  output  1 each  word valid, first word of packet, last word of packet.
REQ-015 Port sched_busy, sched_done  output  1 each  capture in progress; capture finished.
REQ-016 Port pkt_cnt  output  PKT_CNT_W  number of completed packets.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, SEND, GAP and DONE.
REQ-018 A rising edge on rf_capture_start SHALL be detected against a registered copy of the signal.
REQ-019 A rising edge detected while in IDLE SHALL move the FSM to SEND on the next cycle; rising edges in other states SHALL be ignored.
REQ-020 On entry to SEND from IDLE or DONE, the block SHALL latch rf_96path_en, rf_pkt_data_length and rf_pkt_idle_length, and reset the slot to lane 0, half 0.
REQ-021 The latched values SHALL stay fixed until the next entry from IDLE or DONE; changes to the inputs during a capture SHALL have no effect.
REQ-022 sched_valid SHALL equal (state==SEND) AND DATA_RD_EN, combinationally.
REQ-023 While DATA_RD_EN is low in SEND, lane_sel, half_sel and the word count SHALL hold.
REQ-024 The slot SHALL advance on each valid word: half_sel toggles first; lane_sel increments on the 1->0 transition of half_sel.
REQ-025 lane_sel SHALL wrap to 0 after lane 23 when the latched 96path value is 1, and after lane 11 when it is 0.
REQ-026 The slot SHALL continue across packets within one capture.
REQ-027 sched_sop SHALL be high on the valid word with word count 0; sched_eop SHALL be high on the valid word with word count L-1.
REQ-028 A word with sched_eop SHALL increment pkt_cnt, which wraps at 2^PKT_CNT_W.
REQ-029 After the eop word, the next state SHALL be chosen as follows.
  - rf_capture_mode=0, or rf_capture_start low: DONE.
  - Otherwise, latched idle length > 0: GAP.
  - Otherwise (idle = 0): remain in SEND with word count 0, giving back-to-back packets.
REQ-030 GAP SHALL last exactly the latched idle length in cycles, then return to SEND without resetting the slot.
REQ-031 Lowering rf_capture_start during SEND or GAP SHALL never truncate a packet; the current packet completes, and in GAP the FSM goes to DONE when the gap ends.
REQ-032 In DONE, a pulse on rf_capture_again SHALL move the FSM to SEND on the next cycle (re-latching per REQ-020).
REQ-033 In DONE, rf_capture_start low with no rf_capture_again pulse SHALL move the FSM to IDLE; if both occur in the same cycle, rf_capture_again SHALL win.
REQ-034 rf_capture_again SHALL be ignored in IDLE, SEND and GAP.
REQ-035 sched_busy SHALL be high in SEND and GAP; sched_done SHALL be high in DONE.

Reset
REQ-036 While pktctrl_rst is high at a clock edge, the block SHALL enter IDLE, including mid-packet or mid-gap.
REQ-037 During reset, all outputs SHALL be 0, pkt_cnt SHALL be 0, and the registered start copy SHALL be 0.
REQ-038 A start level already high when reset releases SHALL NOT produce a capture; a new rising edge is required.

Configuration
REQ-039 With PKT_SCHED_PKT_CNT_EN defined, pkt_cnt SHALL be implemented as in REQ-028.
REQ-040 Without PKT_SCHED_PKT_CNT_EN, pkt_cnt SHALL be tied to 0 and no counter flops SHALL exist; all other behaviour is unchanged.

Verification
REQ-041 Single-packet capture: mode=0, length=00, DATA_RD_EN=1, start edge -> 64 valid words; sop on word 0, eop on word 63; lane sequence 0,0,1,1..23,23,0..7,7; then DONE, pkt_cnt=1.
REQ-042 Lane wrap with 12 lanes: 96path=0, length=01 -> lane_sel wraps 11->0 after every 24 words; no lane_sel above 11.
REQ-043 Read-enable gaps: DATA_RD_EN toggles 1,0,0,1 per cycle -> valid only in RD_EN cycles, slot holds during gaps, still exactly 64 words.
REQ-044 Continuous mode with idle gap: mode=1, idle=5, start held high -> exactly 5 non-valid cycles between eop and the next sop; start dropped mid-packet -> packet completes, then DONE.
REQ-045 Back-to-back, reset and re-arm: idle=0 -> sop immediately follows eop; reset asserted mid-SEND -> all outputs 0 the next cycle; rf_capture_again in DONE -> new packet starting at lane 0.
